// File: rtl/fir_sequencer.sv
// -----------------------------------------------------------------------------
// fir_sequencer
//
// Control FSM for a folded symmetric FIR datapath. The datapath has two
// address-shift registers, a symmetric-pair adder, a coefficient ROM and a MAC.
// The sequencer accepts one sample per valid/ready handshake. For each sample
// it steps the tap addresses through the H = N_TAPS/2 symmetric pairs. It
// then lets the product pipeline drain and pulses the output-register load.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   in_valid   in   sample present at the datapath input register
//   in_ready   out  sequencer can accept a sample (IDLE or DONE)
//   shift_en   out  one-cycle pulse: load input register, shift both ASRs
//   tap_up     out  forward ASR address / ROM address (0..H-1)
//   tap_down   out  reverse ASR address (H-1..0)
//   addr_valid out  tap_up/tap_down meaningful this cycle
//   mac_clr    out  one-cycle pulse: zero the accumulator
//   mac_en     out  accumulate product at MAC input (addr_valid delayed PIPE_LAT)
//   out_load   out  one-cycle pulse: capture MAC result
//   busy       out  FSM not idle
// -----------------------------------------------------------------------------
module fir_sequencer #(
  parameter int N_TAPS   = 16,
  parameter int PIPE_LAT = 3,
  parameter int AW       = $clog2(N_TAPS / 2)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          shift_en,
  output logic [AW-1:0] tap_up,
  output logic [AW-1:0] tap_down,
  output logic          addr_valid,
  output logic          mac_clr,
  output logic          mac_en,
  output logic          out_load,
  output logic          busy
);

  localparam int H  = N_TAPS / 2;
  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  localparam logic [AW-1:0] K_LAST = AW'(H - 1);
  localparam logic [DW-1:0] D_LAST = DW'(PIPE_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [AW-1:0]         k_q, k_d;
  logic [DW-1:0]         d_q, d_d;
  logic [PIPE_LAT-1:0]   pipe_q, pipe_d;

  logic                  in_ready_q, in_ready_d;
  logic                  shift_en_q, shift_en_d;
  logic [AW-1:0]         tap_up_q, tap_up_d;
  logic [AW-1:0]         tap_down_q, tap_down_d;
  logic                  addr_valid_q, addr_valid_d;
  logic                  mac_clr_q, mac_clr_d;
  logic                  out_load_q, out_load_d;
  logic                  busy_q, busy_d;

  // Next-state logic for the FSM and its two index counters.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    d_d     = d_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        k_d     = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        // k only returns to zero when RUN is left, so addresses stay below H.
        if (k_q == K_LAST) begin
          k_d     = '0;
          d_d     = '0;
          state_d = S_DRAIN;
        end else begin
          k_d     = k_q + AW'(1);
        end
      end
      S_DRAIN: begin
        if (d_q == D_LAST) begin
          d_d     = '0;
          state_d = S_DONE;
        end else begin
          d_d     = d_q + DW'(1);
        end
      end
      S_DONE: begin
        if (in_valid) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        k_d     = '0;
        d_d     = '0;
      end
    endcase
  end

  // Compute the output values from the next state. Registering these values
  // gives glitch-free outputs that still line up with the state decode.
  always_comb begin
    in_ready_d   = (state_d == S_IDLE) || (state_d == S_DONE);
    shift_en_d   = (state_d == S_LOAD);
    mac_clr_d    = (state_d == S_LOAD);
    addr_valid_d = (state_d == S_RUN);
    out_load_d   = (state_d == S_DONE);
    busy_d       = (state_d != S_IDLE);
    if (state_d == S_RUN) begin
      tap_up_d   = k_d;
      tap_down_d = K_LAST - k_d;
    end else begin
      tap_up_d   = '0;
      tap_down_d = '0;
    end
    // Delay line: bit 0 is addr_valid one cycle late, and the MSB is PIPE_LAT late.
    pipe_d    = pipe_q << 1;
    pipe_d[0] = addr_valid_q;
  end

  // State, counters, delay line and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      k_q          <= '0;
      d_q          <= '0;
      pipe_q       <= '0;
      in_ready_q   <= 1'b1;
      shift_en_q   <= 1'b0;
      tap_up_q     <= '0;
      tap_down_q   <= '0;
      addr_valid_q <= 1'b0;
      mac_clr_q    <= 1'b0;
      out_load_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      d_q          <= d_d;
      pipe_q       <= pipe_d;
      in_ready_q   <= in_ready_d;
      shift_en_q   <= shift_en_d;
      tap_up_q     <= tap_up_d;
      tap_down_q   <= tap_down_d;
      addr_valid_q <= addr_valid_d;
      mac_clr_q    <= mac_clr_d;
      out_load_q   <= out_load_d;
      busy_q       <= busy_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign shift_en   = shift_en_q;
  assign tap_up     = tap_up_q;
  assign tap_down   = tap_down_q;
  assign addr_valid = addr_valid_q;
  assign mac_clr    = mac_clr_q;
  assign mac_en     = pipe_q[PIPE_LAT-1];
  assign out_load   = out_load_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_fir_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fir_sequencer
//
// Tests two configurations: the default (16 taps, latency 3) and the smallest
// corner (4 taps, latency 1). In each configuration a reference model tracks
// "cycles since the accepted handshake" and derives every output from the
// sample timeline. After every clock edge the driver pushes the expected
// outputs into a queue. The monitor pops from that queue on the falling edge
// and compares the entry against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_fir_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  logic done_s [2] = '{1'b0, 1'b0};

  typedef struct packed {
    logic       in_ready;
    logic       shift_en;
    logic       addr_valid;
    logic       mac_clr;
    logic       mac_en;
    logic       out_load;
    logic       busy;
    logic [7:0] tap_up;
    logic [7:0] tap_down;
  } exp_t;

  // Outputs expected in the cycle that is 'off' cycles after the handshake
  // (off = 0 means no sample in flight).
  function automatic exp_t model(input int off, input int h, input int l);
    exp_t e;
    int   p;
    p            = h + l + 2;
    e.in_ready   = (off == 0) || (off == p);
    e.shift_en   = (off == 1);
    e.mac_clr    = (off == 1);
    e.addr_valid = (off >= 2) && (off <= h + 1);
    e.mac_en     = (off >= l + 2) && (off <= l + h + 1);
    e.out_load   = (off == p);
    e.busy       = (off != 0);
    e.tap_up     = e.addr_valid ? 8'(off - 2) : 8'd0;
    e.tap_down   = e.addr_valid ? 8'(h - 1 - (off - 2)) : 8'd0;
    return e;
  endfunction

  task automatic chk(input int g, input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL cfg%0d %s at %0t: got %0d, want %0d", g, name, $time, act, req);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int NT = (g == 0) ? 16 : 4;
    localparam int PL = (g == 0) ? 3 : 1;
    localparam int H  = NT / 2;
    localparam int P  = H + PL + 2;
    localparam int AW = $clog2(H);
    localparam int KR = H / 2;

    logic          rst_s      = 1'b0;
    logic          in_valid_s = 1'b0;
    logic          in_ready_s, shift_en_s, addr_valid_s, mac_clr_s;
    logic          mac_en_s, out_load_s, busy_s;
    logic [AW-1:0] tap_up_s, tap_down_s;
    int            off = 0;
    exp_t          exp_q [$];

    fir_sequencer #(.N_TAPS(NT), .PIPE_LAT(PL)) dut (
      .clk        (clk),
      .rst        (rst_s),
      .in_valid   (in_valid_s),
      .in_ready   (in_ready_s),
      .shift_en   (shift_en_s),
      .tap_up     (tap_up_s),
      .tap_down   (tap_down_s),
      .addr_valid (addr_valid_s),
      .mac_clr    (mac_clr_s),
      .mac_en     (mac_en_s),
      .out_load   (out_load_s),
      .busy       (busy_s)
    );

    // Advance one edge. The task updates the model from the inputs that were
    // applied during the last cycle and queues the expectation for the new
    // cycle. It then applies the next inputs. When a new reset is applied
    // between clock edges, it takes effect at once in the same cycle.
    task automatic step(input logic nrst, input logic nvalid);
      @(posedge clk);
      if (!rst_s)                               off = 0;
      else if ((off == 0 || off == P) && in_valid_s) off = 1;
      else if (off == P)                        off = 0;
      else if (off != 0)                        off = off + 1;
      if (!nrst) off = 0;
      exp_q.push_back(model(off, H, PL));
      #1;
      rst_s      = nrst;
      in_valid_s = nvalid;
    endtask

    always @(negedge clk) begin : mon
      exp_t e;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(g, "in_ready",   int'(in_ready_s),   int'(e.in_ready));
        chk(g, "shift_en",   int'(shift_en_s),   int'(e.shift_en));
        chk(g, "mac_clr",    int'(mac_clr_s),    int'(e.mac_clr));
        chk(g, "addr_valid", int'(addr_valid_s), int'(e.addr_valid));
        chk(g, "tap_up",     int'(tap_up_s),     int'(e.tap_up));
        chk(g, "tap_down",   int'(tap_down_s),   int'(e.tap_down));
        chk(g, "mac_en",     int'(mac_en_s),     int'(e.mac_en));
        chk(g, "out_load",   int'(out_load_s),   int'(e.out_load));
        chk(g, "busy",       int'(busy_s),       int'(e.busy));
      end
    end

    initial begin : drv
      // Hold reset with in_valid high, then release it into back-to-back operation.
      repeat (3) step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      repeat (4 * P) step(1'b1, 1'b1);
      // Return to idle, then send one isolated sample.
      repeat (P + 2) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      repeat (P + 3) step(1'b1, 1'b0);
      // Pulse in_valid for one cycle in the middle of RUN. The DUT must ignore it.
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      repeat (P + 3) step(1'b1, 1'b0);
      // Assert reset while k = KR, then run a normal sample.
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      repeat (KR) step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      repeat (P + 2) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      repeat (P + 3) step(1'b1, 1'b0);
      // Random traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
        step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0));
      end
      repeat (3) step(1'b1, 1'b0);
      done_s[g] = 1'b1;
    end
  end

  initial begin : fin
    int cycles;
    for (cycles = 0; cycles < 5000 && !(done_s[0] && done_s[1]); cycles++) begin
      @(posedge clk);
    end
    if (!(done_s[0] && done_s[1])) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: drivers not finished after %0d cycles, want done", cycles);
    end
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fir_sequencer.md
# fir_sequencer

Single-clock control FSM for the folded symmetric FIR datapath: the two address-shift registers (ASRs), the symmetric-pair adder, the coefficient ROM and the MAC. It accepts one input sample per valid/ready handshake and issues the ASR shift strobe, the forward and reverse tap addresses, the ROM address, and the MAC clear and enable strobes. When the MAC result is final, it pulses the output-register load. It replaces free-running counters and a divided clock with explicit sequencing on the system clock.

## Interface
Parameters:
- N_TAPS, 16, filter length. Must be even and ≥ 4. H = N_TAPS/2 symmetric pairs.
- PIPE_LAT, 3, cycles from the address being presented to the product being available at the MAC input (ASR read, adder register, ROM register). Must be ≥ 1.
- AW, $clog2(N_TAPS/2), width of the tap address.

Ports:
- clk  in  1  system clock; everything is on the rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  a new sample is present at the datapath input register
- in_ready  out  1  sequencer can accept a sample
- shift_en  out  1  one-cycle pulse: load the input register and shift both ASRs by one
- tap_up  out  AW  forward ASR address, also the ROM address
- tap_down  out  AW  reverse ASR address
- addr_valid  out  1  tap_up/tap_down are meaningful this cycle
- mac_clr  out  1  one-cycle pulse: zero the accumulator
- mac_en  out  1  accumulate the product present at the MAC input
- out_load  out  1  one-cycle pulse: capture the MAC result into the output register
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE: in_ready=1. If in_valid=1, the handshake completes and the next state is LOAD.
- LOAD (1 cycle):
  - shift_en=1, mac_clr=1.
  - The index counter k is set to 0. Next state is RUN.
- RUN (H cycles):
  - addr_valid=1, tap_up=k, tap_down=H-1-k.
  - k increments each cycle. When k=H-1, the next state is DRAIN.
- DRAIN (PIPE_LAT cycles): a drain counter runs from 0 to PIPE_LAT-1, then the next state is DONE.
- DONE (1 cycle):
  - out_load=1, in_ready=1.
  - If in_valid=1, the next state is LOAD (back-to-back operation). Otherwise the next state is IDLE.
- mac_en is addr_valid delayed by exactly PIPE_LAT cycles through an internal shift register. It is high for exactly H cycles per sample and ends on the last DRAIN cycle.
- In IDLE, LOAD and DONE, tap_up and tap_down hold 0.
- The counter k wraps only through the state change. No address ever exceeds H-1.
- in_valid is sampled only while in_ready=1. in_valid in any other state is ignored and not queued.

## Timing
- Reset (rst=0), asynchronous and immediate:
  - State goes to IDLE, k=0, the drain counter is 0 and the mac_en delay line is cleared.
  - Reset values: in_ready=1; shift_en, addr_valid, mac_clr, mac_en, out_load and busy =0; tap_up=0, tap_down=0.
- Reset mid-operation aborts the sample. No out_load is produced for it.
- Handshake at edge T: LOAD occupies cycle T+1, RUN occupies T+2..T+H+1, DRAIN occupies T+H+2..T+H+PIPE_LAT+1, and out_load is asserted in cycle T+H+PIPE_LAT+2.
- Sample period: H+PIPE_LAT+2 cycles with back-to-back acceptance in DONE. It is one cycle longer when passing through IDLE. Defaults give 13 cycles.
- mac_clr (LOAD) always precedes the first mac_en by PIPE_LAT+1 cycles and never coincides with it.
- All outputs are registered or decoded directly from state. There are no combinational paths from in_valid, except that the DONE/IDLE→LOAD transition takes effect at the next edge.

## Test plan
- Reset and idle: hold rst=0 for 3 cycles with in_valid=1, then release. During reset, in_ready=1 and all strobes are 0. The first handshake occurs at the first edge after release.
- Single sample (N_TAPS=16, PIPE_LAT=3), handshake at edge 0:
  - shift_en and mac_clr are high in cycle 1.
  - tap_up runs 0..7 and tap_down runs 7..0 in cycles 2..9.
  - mac_en is high in cycles 5..12.
  - out_load is high in cycle 13. Then IDLE.
- Back-to-back: in_valid held at 1. LOAD pulses occur every 13 cycles and out_load every 13 cycles. Exactly 8 mac_en cycles occur between consecutive mac_clr pulses.
- Ignored request: in_valid is pulsed for 1 cycle during RUN. There is no extra LOAD, and in_ready stays 0 until DONE.
- Reset mid-RUN: assert rst=0 at k=4. Outputs go to reset values immediately. No out_load follows. The next sample sequences normally from LOAD.
- Parameter corners: with N_TAPS=4 and PIPE_LAT=1, addresses run 0,1 and 1,0, mac_en is high 2 cycles, and the period is 5 cycles.
